alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
//   32-bit integer ALU for the single-cycle/pipelined CPU datapath.
//   Computes add/sub/and/or/logical-right-shift/arithmetic-right-shift of A and B, selected by ALUop.
//   The result is registered: one-cycle latency, output C held stable between clock edges.
//   Feeds the writeback/memory-address path; carries no overflow or flag outputs.
// PARAMETERS
//   WIDTH   32   Data width of A, B and C. Only 32 is verified.
// PORTS
//   clk     in   1      System clock; all state updates on the rising edge.
//   reset   in   1      Synchronous, active-high reset.
//   A       in   WIDTH  Operand A; this is the operand shifted by the shift ops.
//   B       in   WIDTH  Operand B; this is the shift amount for the shift ops.
//   ALUop   in   3      Operation select.
//   C       out  WIDTH  Registered result.
// BEHAVIOUR
//   - Single clock, synchronous active-high reset.
//   - If reset=1 at a rising edge: C <= 0 (overrides any op).
//   - Otherwise, at each rising edge C <= f(A, B, ALUop), sampled at that edge.
//   - Latency is exactly 1 cycle. There is no handshake; a new op is accepted every cycle.
//   - Op table:
//     000  ADD  A + B, modulo 2^32. Carry is discarded.
//     001  SUB  A - B, modulo 2^32. Borrow is discarded.
//     010  AND  A & B.
//     011  OR   A | B.
//     100  SRL  A >> B, logical; zero-fill from the MSB.
//     101  SRA  A >>> B, arithmetic; fill with A[31].
//     110, 111  reserved; result is 32'h0.
//   - Shift amount is the full unsigned value of B, not just B[4:0]:
//     B=0 leaves A unchanged.
//     B>=32: SRL gives 0; SRA gives 32'hFFFFFFFF if A[31]=1, else 0.
//   - Operands are unsigned for ADD/SUB; the bit pattern is identical for signed operands.
//   - No X propagation is allowed from the reserved ops.
//   - If reset is deasserted mid-stream, the first post-reset edge registers the then-current inputs.
// STRUCTURE
//   - Shared package alu_pkg holds the ALUop localparams:
//     ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SRL=3'b100, ALU_SRA=3'b101.
//   - Sub-module alu_shifter (combinational): inputs A, B and an arith flag; output shifted value.
//     It handles the B>=32 saturation rule.
//   - Top level: combinational op mux, then a single output register with synchronous reset.
// TESTING
//   1. reset=1 for 2 cycles with arbitrary inputs -> C=0. Then release reset: C follows ops 1 cycle later.
//   2. ADD: A=FFFFFFFF, B=1 -> C=00000000 (wrap).
//      SUB: A=0, B=1 -> C=FFFFFFFF.
//   3. AND/OR: A=F0F0F0F0, B=FF00FF00 -> AND gives F000F000, OR gives FFF0FFF0.
//   4. SRA: A=F0000000, B=4 -> FF000000.
//      SRL with the same A, B -> 0F000000.
//      SRA with A=70000000, B=4 -> 07000000.
//   5. Shift edges: B=0 -> C=A.
//      A=80000000, B=31: SRA -> FFFFFFFF, SRL -> 00000001.
//      B=32 or B=100: SRL -> 0; SRA with A[31]=1 -> FFFFFFFF.
//   6. Reserved ALUop 110 and 111 with A=B=FFFFFFFF -> C=0.
//      Back-to-back op changes every cycle -> each result appears exactly one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and common widths.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b101;

endpackage

// File: rtl/alu_shifter.sv
// Combinational right shifter (logical or arithmetic) taking the full unsigned
// value of B as the shift amount; amounts >= WIDTH saturate to the fill value.
module alu_shifter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             arith,
  output logic [WIDTH-1:0] Y
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic             fill;
  logic             saturate;
  logic [WIDTH-1:0] stage [ShW+1];

  assign fill     = arith & A[WIDTH-1];
  // Any set bit above the barrel stages means the shift is at least WIDTH.
  assign saturate = |B[WIDTH-1:ShW];
  assign stage[0] = A;

  for (genvar g = 0; g < ShW; g++) begin : g_stage
    localparam int unsigned Dist = 1 << g;
    assign stage[g+1] = B[g] ? {{Dist{fill}}, stage[g][WIDTH-1:Dist]} : stage[g];
  end

  assign Y = saturate ? {WIDTH{fill}} : stage[ShW];

endmodule

// File: rtl/alu_unit.sv
// 32-bit integer ALU: combinational op mux feeding a single result register
// with synchronous active-high reset; one-cycle latency.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALUop,
  output logic [WIDTH-1:0]    C
);

  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] c_q;

  alu_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .A    (A),
    .B    (B),
    .arith(ALUop == ALU_SRA),
    .Y    (shift_res)
  );

  always_comb begin
    c_d = '0;
    case (ALUop)
      ALU_ADD: c_d = A + B;
      ALU_SUB: c_d = A - B;
      ALU_AND: c_d = A & B;
      ALU_OR:  c_d = A | B;
      ALU_SRL: c_d = shift_res;
      ALU_SRA: c_d = shift_res;
      // Reserved encodings drive a clean zero.
      default: c_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign C = c_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed corner cases plus randomized ops,
// expected results queued at issue and checked by an independent monitor.
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUop;
  logic [31:0] C;

  logic [31:0] exp_q [$];
  string       name_q [$];
  int          tests;
  int          fails;

  alu_unit #(
    .WIDTH(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .ALUop(ALUop),
    .C    (C)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic rst, input logic [31:0] a,
                                        input logic [31:0] b, input logic [2:0] op);
    longint unsigned sum;
    if (rst) return 32'h0;
    case (op)
      3'd0: begin
        sum = longint'(a) + longint'(b);
        return sum[31:0];
      end
      3'd1: begin
        sum = (longint'(1) << 32) + longint'(a) - longint'(b);
        return sum[31:0];
      end
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (b >= 32) ? 32'h0 : (a >> b);
      3'd5: begin
        if (b >= 32) return a[31] ? 32'hFFFF_FFFF : 32'h0;
        return a[31] ? ~((~a) >> b) : (a >> b);
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic issue(input string name, input logic rst, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    reset = rst;
    A     = a;
    B     = b;
    ALUop = op;
    exp_q.push_back(model(rst, a, b, op));
    name_q.push_back(name);
  endtask

  // Monitor: each edge retires one queued expectation.
  always @(posedge clk) begin
    logic [31:0] exp_v;
    string       nm;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      tests++;
      if (C !== exp_v) begin
        fails++;
        $display("FAIL %s: C=%08h expected %08h", nm, C, exp_v);
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic        rrst;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    A     = 32'h0;
    B     = 32'h0;
    ALUop = 3'd0;

    issue("reset0", 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd0);
    issue("reset1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd3);

    issue("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0);
    issue("sub_borrow", 1'b0, 32'h0000_0000, 32'h0000_0001, 3'd1);
    issue("and",        1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2);
    issue("or",         1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3);
    issue("sra_neg4",   1'b0, 32'hF000_0000, 32'd4,         3'd5);
    issue("srl_neg4",   1'b0, 32'hF000_0000, 32'd4,         3'd4);
    issue("sra_pos4",   1'b0, 32'h7000_0000, 32'd4,         3'd5);
    issue("srl_b0",     1'b0, 32'hDEAD_BEEF, 32'd0,         3'd4);
    issue("sra_b0",     1'b0, 32'hDEAD_BEEF, 32'd0,         3'd5);
    issue("sra_b31",    1'b0, 32'h8000_0000, 32'd31,        3'd5);
    issue("srl_b31",    1'b0, 32'h8000_0000, 32'd31,        3'd4);
    issue("srl_b32",    1'b0, 32'h8000_0000, 32'd32,        3'd4);
    issue("sra_b32",    1'b0, 32'h8000_0000, 32'd32,        3'd5);
    issue("srl_b100",   1'b0, 32'hFFFF_FFFF, 32'd100,       3'd4);
    issue("sra_b100",   1'b0, 32'h8000_0001, 32'd100,       3'd5);
    issue("sra_pos_b40", 1'b0, 32'h7FFF_FFFF, 32'd40,       3'd5);
    issue("sra_hi_b",   1'b0, 32'h8000_0000, 32'h8000_0001, 3'd5);
    issue("rsvd110",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6);
    issue("rsvd111",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7);
    issue("reset_mid",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3);
    issue("post_reset", 1'b0, 32'h0000_0005, 32'h0000_0007, 3'd0);

    for (int i = 0; i < 2000; i++) begin
      ra  = $urandom();
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 31));
        1: rb = 32'($urandom_range(30, 40));
        2: rb = 32'($urandom_range(0, 255));
        default: rb = $urandom();
      endcase
      rrst = ($urandom_range(0, 49) == 0);
      issue("random", rrst, ra, rb, rop);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
